// File: rtl/ps_pkg.sv
// Shared sequencer definitions: sticky bit indices, ureg addresses and default widths.
package ps_pkg;

    localparam int STK_EMPTY = 0;
    localparam int STK_FULL  = 1;
    localparam int STK_OVF   = 2;
    localparam int STK_UNF   = 3;

    localparam logic [4:0] UREG_PCSTK  = 5'b00100;
    localparam logic [4:0] UREG_PCSTKP = 5'b00101;
    localparam logic [4:0] UREG_STKY   = 5'b11110;

    localparam int PS_AW = 16;

endpackage

// File: rtl/ps_stk_mem.sv
// DEPTH x AW register array: one synchronous write port, one asynchronous read port, no reset.
module ps_stk_mem #(
    parameter int AW    = 16,
    parameter int DEPTH = 4,
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          wen,
    input  logic [IW-1:0] waddr,
    input  logic [AW-1:0] wdata,
    input  logic [IW-1:0] raddr,
    output logic [AW-1:0] rdata
);

    logic [AW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ps_pcstk_ctrl.sv
// Program-sequencer PC stack: pointer, push/pop/ureg-write priority, sticky status.
// Define PS_PCSTK_EVT_EN to build the one-cycle stk_evt overflow/underflow pulse.
module ps_pcstk_ctrl
    import ps_pkg::*;
#(
    parameter int AW    = PS_AW,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_dt,
    input  logic          wr_top,
    input  logic [AW-1:0] wr_dt,
    input  logic          clr_stky,
    output logic [AW-1:0] top_dt,
    output logic [PW-1:0] ptr,
    output logic [3:0]    stky,
    output logic          stk_evt
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Strobes are single-cycle requests with no handshake: each one is
    // consumed on the clock edge it is present for, by priority below.
    logic [PW-1:0] ptr_nxt;
    logic          ovf, unf;
    logic          ovf_evt, unf_evt;
    logic          empty, full;
    logic          wen;
    logic [IW-1:0] waddr, top_idx;
    logic [AW-1:0] wdata, rdata;

    assign empty   = (ptr == '0);
    assign full    = (ptr == PW'(DEPTH));
    assign top_idx = IW'(ptr - PW'(1));

    always_comb begin
        ptr_nxt = ptr;
        wen     = 1'b0;
        waddr   = top_idx;
        wdata   = push_dt;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (push && pop) begin
            wen = !empty;
        end else if (push) begin
            if (!full) begin
                wen     = 1'b1;
                waddr   = IW'(ptr);
                ptr_nxt = ptr + PW'(1);
            end else begin
                ovf_evt = 1'b1;
            end
        end else if (pop) begin
            if (!empty) begin
                ptr_nxt = ptr - PW'(1);
            end else begin
                unf_evt = 1'b1;
            end
        end else if (wr_top && !empty) begin
            wen   = 1'b1;
            wdata = wr_dt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ptr <= ptr_nxt;
            // A new event outranks a simultaneous clear.
            ovf <= ovf_evt | (ovf & ~clr_stky);
            unf <= unf_evt | (unf & ~clr_stky);
        end
    end

`ifdef PS_PCSTK_EVT_EN
    logic evt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_q <= 1'b0;
        end else begin
            evt_q <= ovf_evt | unf_evt;
        end
    end

    assign stk_evt = evt_q;
`else
    assign stk_evt = 1'b0;
`endif

    ps_stk_mem #(
        .AW   (AW),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (clk),
        .wen  (wen),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(top_idx),
        .rdata(rdata)
    );

    assign top_dt = empty ? '0 : rdata;

    always_comb begin
        stky            = '0;
        stky[STK_EMPTY] = empty;
        stky[STK_FULL]  = full;
        stky[STK_OVF]   = ovf;
        stky[STK_UNF]   = unf;
    end

endmodule

// File: tb/tb_ps_pcstk_ctrl.sv
// Self-checking bench for ps_pcstk_ctrl: directed scenarios plus random strobes against a queue model.
module tb_ps_pcstk_ctrl;

    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam int PW    = 3;

`ifdef PS_PCSTK_EVT_EN
    localparam bit EVT_ON = 1'b1;
`else
    localparam bit EVT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          push = 1'b0, pop = 1'b0, wr_top = 1'b0, clr_stky = 1'b0;
    logic [AW-1:0] push_dt = '0, wr_dt = '0;
    logic [AW-1:0] top_dt;
    logic [PW-1:0] ptr;
    logic [3:0]    stky;
    logic          stk_evt;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: the stack is a queue, back = top.
    logic [AW-1:0] model_q[$];
    bit            m_ovf, m_unf, m_evt;

    ps_pcstk_ctrl #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .push_dt (push_dt),
        .wr_top  (wr_top),
        .wr_dt   (wr_dt),
        .clr_stky(clr_stky),
        .top_dt  (top_dt),
        .ptr     (ptr),
        .stky    (stky),
        .stk_evt (stk_evt)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] exp_top();
        return (model_q.size() == 0) ? '0 : model_q[model_q.size()-1];
    endfunction

    function automatic logic [3:0] exp_stky();
        return {m_unf, m_ovf, model_q.size() == DEPTH, model_q.size() == 0};
    endfunction

    task automatic model_reset();
        model_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_evt = 1'b0;
    endtask

    // Drive one cycle of strobes, update the model at the edge, return #1 after it with idle inputs.
    task automatic drive(input bit p, input bit q, input logic [AW-1:0] pd,
                         input bit w, input logic [AW-1:0] wd, input bit c);
        bit oe, ue;
        push = p; pop = q; push_dt = pd; wr_top = w; wr_dt = wd; clr_stky = c;
        @(posedge clk);
        oe = 1'b0;
        ue = 1'b0;
        if (p && q) begin
            if (model_q.size() != 0) model_q[model_q.size()-1] = pd;
        end else if (p) begin
            if (model_q.size() < DEPTH) model_q.push_back(pd);
            else oe = 1'b1;
        end else if (q) begin
            if (model_q.size() != 0) void'(model_q.pop_back());
            else ue = 1'b1;
        end else if (w && model_q.size() != 0) begin
            model_q[model_q.size()-1] = wd;
        end
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (oe) m_ovf = 1'b1;
        if (ue) m_unf = 1'b1;
        m_evt = EVT_ON & (oe | ue);
        #1;
        push = 1'b0; pop = 1'b0; wr_top = 1'b0; clr_stky = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        vec_cnt++;
        if (ptr !== 3'd0 || stky !== 4'b0001 || top_dt !== 16'h0 || stk_evt !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset: ptr=%0d stky=%b top=%h evt=%b, want 0 0001 0000 0", ptr, stky, top_dt, stk_evt);
        end
    endtask

    task automatic test_underflow();
        drive(0, 1, '0, 0, '0, 0);
        vec_cnt++;
        if (ptr !== 3'd0 || stky !== 4'b1001 || stk_evt !== EVT_ON) begin
            err_cnt++;
            $display("FAIL underflow: ptr=%0d stky=%b evt=%b, want 0 1001 %b", ptr, stky, stk_evt, EVT_ON);
        end
        drive(0, 0, '0, 0, '0, 0);
        vec_cnt++;
        if (stky !== 4'b1001 || stk_evt !== 1'b0) begin
            err_cnt++;
            $display("FAIL unf_sticky: stky=%b evt=%b, want 1001 0", stky, stk_evt);
        end
        drive(0, 0, '0, 0, '0, 1);
        vec_cnt++;
        if (stky !== 4'b0001) begin
            err_cnt++;
            $display("FAIL unf_clear: stky=%b, want 0001", stky);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 4; i++) drive(1, 0, AW'(16 * i), 0, '0, 0);
        vec_cnt++;
        if (ptr !== 3'd4 || stky !== 4'b0010 || top_dt !== 16'h0040) begin
            err_cnt++;
            $display("FAIL fill: ptr=%0d stky=%b top=%h, want 4 0010 0040", ptr, stky, top_dt);
        end
        drive(1, 0, 16'h0050, 0, '0, 0);
        vec_cnt++;
        if (ptr !== 3'd4 || stky !== 4'b0110 || top_dt !== 16'h0040 || stk_evt !== EVT_ON) begin
            err_cnt++;
            $display("FAIL overflow: ptr=%0d stky=%b top=%h evt=%b, want 4 0110 0040 %b",
                     ptr, stky, top_dt, stk_evt, EVT_ON);
        end
        drive(0, 0, '0, 0, '0, 0);
        vec_cnt++;
        if (stk_evt !== 1'b0) begin
            err_cnt++;
            $display("FAIL evt_one_cycle: evt=%b, want 0", stk_evt);
        end
    endtask

    task automatic test_drain();
        for (int i = 4; i >= 1; i--) begin
            vec_cnt++;
            if (top_dt !== AW'(16 * i)) begin
                err_cnt++;
                $display("FAIL drain_top: top=%h, want %h", top_dt, AW'(16 * i));
            end
            drive(0, 1, '0, 0, '0, 0);
        end
        vec_cnt++;
        if (ptr !== 3'd0 || stky !== 4'b0101) begin
            err_cnt++;
            $display("FAIL drained: ptr=%0d stky=%b, want 0 0101", ptr, stky);
        end
        drive(0, 0, '0, 0, '0, 1);
        vec_cnt++;
        if (stky !== 4'b0001) begin
            err_cnt++;
            $display("FAIL drain_clear: stky=%b, want 0001", stky);
        end
    endtask

    task automatic test_push_pop();
        drive(1, 0, 16'h0010, 0, '0, 0);
        drive(1, 0, 16'h0020, 0, '0, 0);
        drive(1, 1, 16'h0AAA, 0, '0, 0);
        vec_cnt++;
        if (ptr !== 3'd2 || top_dt !== 16'h0AAA || stky !== 4'b0000) begin
            err_cnt++;
            $display("FAIL push_pop_replace: ptr=%0d top=%h stky=%b, want 2 0aaa 0000", ptr, top_dt, stky);
        end
        drive(0, 1, '0, 0, '0, 0);
        vec_cnt++;
        if (top_dt !== 16'h0010) begin
            err_cnt++;
            $display("FAIL push_pop_below: top=%h, want 0010", top_dt);
        end
        drive(0, 1, '0, 0, '0, 0);
        drive(1, 1, 16'h0BBB, 0, '0, 0);
        vec_cnt++;
        if (ptr !== 3'd0 || stky !== 4'b0001 || top_dt !== 16'h0 || stk_evt !== 1'b0) begin
            err_cnt++;
            $display("FAIL push_pop_empty: ptr=%0d stky=%b top=%h evt=%b, want 0 0001 0000 0",
                     ptr, stky, top_dt, stk_evt);
        end
    endtask

    task automatic test_wr_top();
        drive(1, 0, 16'h0010, 0, '0, 0);
        drive(0, 0, '0, 1, 16'h1234, 0);
        vec_cnt++;
        if (ptr !== 3'd1 || top_dt !== 16'h1234) begin
            err_cnt++;
            $display("FAIL wr_top: ptr=%0d top=%h, want 1 1234", ptr, top_dt);
        end
        drive(1, 0, 16'h0055, 1, 16'h9999, 0);
        vec_cnt++;
        if (ptr !== 3'd2 || top_dt !== 16'h0055) begin
            err_cnt++;
            $display("FAIL wr_top_with_push: ptr=%0d top=%h, want 2 0055", ptr, top_dt);
        end
        drive(0, 1, '0, 0, '0, 0);
        vec_cnt++;
        if (ptr !== 3'd1 || top_dt !== 16'h1234) begin
            err_cnt++;
            $display("FAIL wr_top_entry0: ptr=%0d top=%h, want 1 1234", ptr, top_dt);
        end
        drive(0, 1, '0, 1, 16'h7777, 0);
        vec_cnt++;
        if (ptr !== 3'd0 || top_dt !== 16'h0) begin
            err_cnt++;
            $display("FAIL wr_top_with_pop: ptr=%0d top=%h, want 0 0000", ptr, top_dt);
        end
        drive(0, 0, '0, 1, 16'h4321, 0);
        vec_cnt++;
        if (ptr !== 3'd0 || top_dt !== 16'h0 || stky !== 4'b0001) begin
            err_cnt++;
            $display("FAIL wr_top_empty: ptr=%0d top=%h stky=%b, want 0 0000 0001", ptr, top_dt, stky);
        end
    endtask

    task automatic test_clr_coincide();
        for (int i = 0; i < 4; i++) drive(1, 0, AW'(i + 1), 0, '0, 0);
        drive(1, 0, 16'hDEAD, 0, '0, 1);
        vec_cnt++;
        if (stky !== 4'b0110 || top_dt !== 16'h0004) begin
            err_cnt++;
            $display("FAIL clr_vs_ovf: stky=%b top=%h, want 0110 0004", stky, top_dt);
        end
    endtask

    task automatic test_async_reset();
        drive(0, 1, '0, 0, '0, 0);
        vec_cnt++;
        if (ptr !== 3'd3) begin
            err_cnt++;
            $display("FAIL pre_reset_ptr: ptr=%0d, want 3", ptr);
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        vec_cnt++;
        if (ptr !== 3'd0 || stky !== 4'b0001 || top_dt !== 16'h0) begin
            err_cnt++;
            $display("FAIL async_reset: ptr=%0d stky=%b top=%h, want 0 0001 0000", ptr, stky, top_dt);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bit p, q, w, c;
            p = ($urandom_range(0, 99) < 45);
            q = ($urandom_range(0, 99) < 40);
            w = ($urandom_range(0, 99) < 30);
            c = ($urandom_range(0, 99) < 10);
            vec_cnt++;
            if (top_dt !== exp_top()) begin
                err_cnt++;
                $display("FAIL rand_pre_top[%0d]: top=%h, want %h", n, top_dt, exp_top());
            end
            drive(p, q, AW'($urandom), w, AW'($urandom), c);
            vec_cnt++;
            if (ptr !== PW'(model_q.size()) || stky !== exp_stky() || top_dt !== exp_top()
                || stk_evt !== m_evt) begin
                err_cnt++;
                $display("FAIL rand[%0d]: ptr=%0d stky=%b top=%h evt=%b, want %0d %b %h %b",
                         n, ptr, stky, top_dt, stk_evt, model_q.size(), exp_stky(), exp_top(), m_evt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_underflow();
        test_fill_overflow();
        test_drain();
        test_push_pop();
        test_wr_top();
        test_clr_coincide();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ps_pcstk_ctrl.md
Name: ps_pcstk_ctrl

Overview:
Parametrised program-sequencer PC stack that replaces the single-entry PCSTK/PCSTKP/sticky logic in the sequencer top.
- Holds DEPTH return addresses of width AW.
- Serves call/return and explicit push/pop, ureg writes to the top of stack, and readback of top, pointer and sticky status.
- Sits between sequencer control (call/rtrn/push/pop strobes) and the ureg/bus-connect read-write path.

Parameters:
AW, 16, address/data width of one stack entry
DEPTH, 4, number of stack entries (>=2)
PW, $clog2(DEPTH+1), pointer width (localparam, derived, not overridable)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
push  in  1  push push_dt this cycle (call or push-stack instruction)
pop  in  1  pop top this cycle (return or pop-stack instruction)
push_dt  in  AW  data pushed (return address / ureg data)
wr_top  in  1  ureg write to PCSTK: overwrite top entry
wr_dt  in  AW  data for wr_top
clr_stky  in  1  clear sticky overflow/underflow bits
top_dt  out  AW  current top entry; 0 when empty
ptr  out  PW  entry count, 0..DEPTH
stky  out  4  {unf, ovf, full, empty}
stk_evt  out  1  one-cycle pulse on an overflow or underflow event (optional feature only)

Behaviour:
- Reset (async, rst=0):
  - ptr=0; stky=4'b0001; stk_evt=0; top_dt=0.
  - Storage contents are don't-care and are not reset.
- All state updates occur on posedge clk. Outputs are combinational from registered state, so a push/pop/wr_top is visible on top_dt/ptr the cycle after the strobe.
- empty = (ptr==0). full = (ptr==DEPTH). Both are live, not sticky.
- top_dt = mem[ptr-1] when ptr!=0, else 0.
- Event priority each cycle, evaluating only the first applicable row:
  1. push & pop & !empty: replace top with push_dt; ptr unchanged; no flags.
  2. push & pop & empty: no-op; no flags.
  3. push & !full: mem[ptr]<=push_dt; ptr<=ptr+1.
  4. push & full: data discarded; ptr unchanged; ovf<=1.
  5. pop & !empty: ptr<=ptr-1. Popped value is top_dt in the strobe cycle.
  6. pop & empty: ptr unchanged; unf<=1.
  7. wr_top & !empty: mem[ptr-1]<=wr_dt.
  8. wr_top & empty: ignored; no flag.
- wr_top is ignored whenever push or pop is asserted in the same cycle.
- ovf/unf:
  - Sticky until clr_stky.
  - If clr_stky coincides with a new overflow/underflow event, the event wins (bit stays 1).
  - clr_stky does not affect empty/full or ptr.
- Pointer never wraps. Saturation is enforced by rows 4 and 6.
- Reset asserted mid-operation returns to the reset state immediately; pending strobes are lost.

Optional Feature:
Macro PS_PCSTK_EVT_EN.
- Defined: stk_evt pulses high for exactly one cycle, the cycle after any overflow (row 4) or underflow (row 6) event, regardless of the sticky state. The sequencer uses it as an exception request.
- Not defined: stk_evt is tied to 0 and its register is not built. All other behaviour is identical.

Decomposition:
- Shared package ps_pkg holds:
  - Sticky bit index constants: STK_EMPTY=0, STK_FULL=1, STK_OVF=2, STK_UNF=3.
  - Ureg addresses PCSTK=5'b00100, PCSTKP=5'b00101, STKY=5'b11110.
  - Default AW.
- One sub-module, ps_stk_mem: a DEPTH x AW register array with one write port (addr, data, en) and one async read port. It has no reset.
- ps_pcstk_ctrl owns the pointer, the priority logic, the sticky bits and the event pulse.

Test Plan (DEPTH=4, AW=16):
- Reset → ptr=0, stky=4'b0001, top_dt=0. Pop when empty → unf set, stky=4'b1001, ptr=0.
- Push 0x0010, 0x0020, 0x0030, 0x0040 → ptr=4, stky=4'b0010, top_dt=0x0040. Push 0x0050 → ptr=4, top_dt=0x0040, stky=4'b0110; with PS_PCSTK_EVT_EN, stk_evt high for one cycle.
- From full, pop four times → top_dt sequence 0x0040, 0x0030, 0x0020, 0x0010 in the pop cycles; final ptr=0, empty=1, ovf still 1. Then clr_stky → stky=4'b0001.
- ptr=2 (top 0x0020): push=pop=1 with push_dt=0x0AAA → ptr=2, top_dt=0x0AAA. Empty stack with push=pop=1 → ptr=0, no flags.
- ptr=1, top 0x0010: wr_top with wr_dt=0x1234 → top_dt=0x1234. wr_top with push=1 (push_dt=0x0055) → ptr=2, top_dt=0x0055, entry 0 still 0x1234. wr_top on empty → no change.
- Push at full with clr_stky=1 → ovf remains 1. Assert rst mid-sequence at ptr=3 → ptr=0, stky=4'b0001 immediately, before the next clock edge.
